// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment driver.
// Segment order is {g,f,e,d,c,b,a}; segments and anodes are active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    DIG0  = 2'd1,
    DIG1  = 2'd2
  } seg7_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_DIG0 = 2'b10;
  localparam logic [1:0] AN_DIG1 = 2'b01;

  localparam logic [6:0] HEX7 [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low seven-segment pattern lookup.
// Purely combinational; the caller registers the result.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for one hex digit
  always_comb begin
    seg = HEX7[nibble];
  end

endmodule

// File: rtl/seg7_display_driver.sv
// Two-digit multiplexed common-anode display driver with guard time.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks a zero upper digit.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] display_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  seg7_state_t   state;
  seg7_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    shadow;
  logic [7:0]    shadow_nxt;
  logic          tick;
  logic          latch;
  logic          lit;
  logic          lead_blank;
  logic [3:0]    nib;
  logic [6:0]    hex_seg;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;

  assign dp = 1'b1;

  // Slot counter wrap and frame latch decision
  always_comb begin
    tick       = (cnt == CNT_MAX);
    cnt_nxt    = tick ? '0 : cnt + CW'(1);
    latch      = tick && (state_nxt == DIG0);
    shadow_nxt = latch ? display_in : shadow;
    lit        = (cnt_nxt >= GUARD_C);
  end

  // Scan sequencer next state: BLANK once, then DIG0/DIG1 forever
  always_comb begin
    state_nxt = state;
    unique case (state)
      BLANK:   if (tick) state_nxt = DIG0;
      DIG0:    if (tick) state_nxt = DIG1;
      DIG1:    if (tick) state_nxt = DIG0;
      default: state_nxt = BLANK;
    endcase
  end

  // Upper digit suppression when its nibble is zero
  always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lead_blank = (shadow_nxt[7:4] == 4'h0);
`else
    lead_blank = 1'b0;
`endif
  end

  // Pick the nibble for the digit that will be active next cycle
  always_comb begin
    nib = (state_nxt == DIG1) ? shadow_nxt[7:4]
                              : shadow_nxt[3:0];
  end

  seg7_hex_decoder u_dec (
    .nibble (nib),
    .seg    (hex_seg)
  );

  // Next anode/segment drive from next-state values
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    unique case (1'b1)
      (state_nxt == DIG0) && lit: begin
        an_nxt  = AN_DIG0;
        seg_nxt = hex_seg;
      end
      (state_nxt == DIG1) && lit && !lead_blank: begin
        an_nxt  = AN_DIG1;
        seg_nxt = hex_seg;
      end
      default: begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
      end
    endcase
  end

  // Sequencer state, slot counter and frame shadow register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= BLANK;
      cnt    <= '0;
      shadow <= 8'h00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
    end
  end

  // Registered pad drivers so the display never sees decode glitches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= latch;
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver (CLK_DIV=4, GUARD=1).
// Honors SEG7_LEADING_ZERO_BLANK_EN when building the expected model.
module tb_seg7_display_driver;

  localparam int CD = 4;
  localparam int GD = 1;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] display_in = 8'h00;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  typedef struct {
    logic [7:0] val;
    logic [6:0] seg0;
    logic [6:0] seg1;
  } vec_t;

  exp_t       sb[$];
  int         t = 0;
  logic [7:0] m_shadow = 8'h00;

  seg7_display_driver #(
    .CLK_DIV (CD),
    .GUARD   (GD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .display_in (display_in),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hexm(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;
      4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;
      4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;
      4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".an"}, 16'(an), 16'h3);
    chk({nm, ".seg"}, 16'(seg), 16'h7F);
    chk({nm, ".dp"}, 16'(dp), 16'h1);
    chk({nm, ".ft"}, 16'(frame_tick), 16'h0);
  endtask

  // One clock: predict post-edge outputs, push, clock, pop, compare.
  task automatic cycle();
    exp_t       e;
    int         tn;
    int         p;
    int         off;
    logic [7:0] sh;
    tn    = t + 1;
    sh    = m_shadow;
    e.an  = 2'b11;
    e.seg = 7'h7F;
    e.ft  = 1'b0;
    if (tn >= CD) begin
      p   = (tn - CD) % (2 * CD);
      off = p % CD;
      if (p == 0) begin
        sh   = display_in;
        e.ft = 1'b1;
      end
      if (off >= GD) begin
        if (p < CD) begin
          e.an  = 2'b10;
          e.seg = hexm(sh[3:0]);
        end else if (!(LZB && sh[7:4] == 4'h0)) begin
          e.an  = 2'b01;
          e.seg = hexm(sh[7:4]);
        end
      end
    end
    sb.push_back(e);
    m_shadow = sh;
    t = tn;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("sb.an", 16'(an), 16'(e.an));
    chk("sb.seg", 16'(seg), 16'(e.seg));
    chk("sb.ft", 16'(frame_tick), 16'(e.ft));
    chk("sb.dp", 16'(dp), 16'h1);
    checks++;
    if (an == 2'b00) begin
      failures++;
      $display("FAIL anode_excl: an=%b at t=%0t", an, $time);
    end
  endtask

  // 0: an==10, 1: an==01, 2: frame_tick
  task automatic wait_for(input int what, input int budget,
                          input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      case (what)
        0:       hit = (an == 2'b10);
        1:       hit = (an == 2'b01);
        default: hit = (frame_tick == 1'b1);
      endcase
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s: event not seen within %0d cycles",
               nm, budget);
    end
  endtask

  // Assert reset mid-cycle, check async blanking, release cleanly.
  task automatic do_reset(input logic [7:0] next_val);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk_idle("rst_hold");
    end
    display_in = next_val;
    reset = 1'b0;
    t = 0;
    m_shadow = 8'h00;
    sb.delete();
  endtask

  vec_t vecs[10];

  initial begin
    int n0;
    int n1;
    int first;

    vecs[0] = '{8'hA5, 7'h12, 7'h08};
    vecs[1] = '{8'h3C, 7'h46, 7'h30};
    vecs[2] = '{8'h7E, 7'h06, 7'h78};
    vecs[3] = '{8'h05, 7'h12, 7'h40};
    vecs[4] = '{8'h00, 7'h40, 7'h40};
    vecs[5] = '{8'hFF, 7'h0E, 7'h0E};
    vecs[6] = '{8'h19, 7'h10, 7'h79};
    vecs[7] = '{8'h2B, 7'h03, 7'h24};
    vecs[8] = '{8'h6D, 7'h21, 7'h02};
    vecs[9] = '{8'h84, 7'h19, 7'h00};

    // Reset state and first-frame timing
    @(posedge clock);
    #1;
    do_reset(8'hA5);
    for (int i = 1; i <= CD; i++) begin
      cycle();
      chk("init.ft", 16'(frame_tick), 16'(i == CD));
      chk("init.an", 16'(an), 16'h3);
    end
    cycle();
    chk("first_light.an", 16'(an), 16'h2);
    chk("first_light.seg", 16'(seg), 16'h12);

    // Table-driven values, one full frame each
    foreach (vecs[k]) begin
      display_in = vecs[k].val;
      wait_for(2, 3 * CD, "vec.latch");
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 2 * CD - 1; i++) begin
        cycle();
        if (an == 2'b10) begin
          n0++;
          chk("vec.seg0", 16'(seg), 16'(vecs[k].seg0));
        end
        if (an == 2'b01) begin
          n1++;
          chk("vec.seg1", 16'(seg), 16'(vecs[k].seg1));
        end
      end
      chk("vec.n0", 16'(n0), 16'(CD - GD));
      if (LZB && vecs[k].val[7:4] == 4'h0)
        chk("vec.n1_blank", 16'(n1), 16'h0);
      else
        chk("vec.n1", 16'(n1), 16'(CD - GD));
    end

    // Tear-free update during a digit-1 slot
    display_in = 8'h3C;
    wait_for(2, 3 * CD, "tear.latch");
    wait_for(1, 2 * CD, "tear.dig1");
    chk("tear.seg_before", 16'(seg), 16'h30);
    display_in = 8'h7E;
    cycle();
    chk("tear.an_hold1", 16'(an), 16'h1);
    chk("tear.seg_hold1", 16'(seg), 16'h30);
    cycle();
    chk("tear.an_hold2", 16'(an), 16'h1);
    chk("tear.seg_hold2", 16'(seg), 16'h30);
    cycle();
    chk("tear.ft", 16'(frame_tick), 16'h1);
    cycle();
    chk("tear.d0_an", 16'(an), 16'h2);
    chk("tear.d0_seg", 16'(seg), 16'h06);
    wait_for(1, 2 * CD, "tear.d1");
    chk("tear.d1_seg", 16'(seg), 16'h78);

    // Asynchronous reset while digit 0 is lit
    display_in = 8'hA5;
    wait_for(0, 3 * CD, "arst.dig0");
    do_reset(8'h00);
    first = 0;
    for (int i = 1; i <= 2 * CD && first == 0; i++) begin
      cycle();
      if (an == 2'b10) first = i;
    end
    chk("arst.first_light", 16'(first), 16'(CD + GD));
    chk("arst.seg", 16'(seg), 16'h40);

    // Random stream: exclusivity and latched-value tracking
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        display_in = 8'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
